// File: rtl/seq_row_multplr_pkg.sv
// Shared definitions for the row-based sequential multiplier: FSM encoding and counter sizing.
package seq_row_multplr_pkg;

  // Encoding 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_row_multplr_row.sv
// One row of the array multiplier: AND-gated partial product added to a running sum
// through a ripple carry chain. Purely combinational.
module comb_arr_multplr_block (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sum_in,
  input  logic i_c_in,
  output logic o_s,
  output logic o_c_out
);
  logic w_pp;

  assign w_pp    = i_a & i_b;
  assign o_s     = w_pp ^ i_sum_in ^ i_c_in;
  assign o_c_out = (w_pp & i_sum_in) | (w_pp & i_c_in) | (i_sum_in & i_c_in);
endmodule

module multplr_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_b,
  input  logic [WIDTH-1:0] i_sum_in,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c
);
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      comb_arr_multplr_block u_cell (
        .i_a      (i_a[gi]),
        .i_b      (i_b),
        .i_sum_in (i_sum_in[gi]),
        .i_c_in   (w_carry[gi]),
        .o_s      (o_s[gi]),
        .o_c_out  (w_carry[gi+1])
      );
    end
  endgenerate

  assign o_c = w_carry[WIDTH];
endmodule

// File: rtl/seq_row_multplr.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier: one array row reused for WIDTH cycles,
// valid/ready handshake on both operand and product sides.
module seq_row_multplr
  import seq_row_multplr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_s;
  logic             w_c;

  multplr_row #(.WIDTH(WIDTH)) u_row (
    .i_a      (r_a),
    .i_b      (r_b[0]),
    .i_sum_in (r_hi),
    .o_s      (w_s),
    .o_c      (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The row's carry-out becomes HI's MSB, so the full 2W-bit product is never truncated.
          r_hi  <= {w_c, w_s[WIDTH-1:1]};
          r_lo  <= {w_s[0], r_lo[WIDTH-1:1]};
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = {r_hi, r_lo};
endmodule

// File: tb/tb_seq_row_multplr.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances checked against plain a*b and the
// documented accept-to-out_valid latency.
module tb_seq_row_multplr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic       in_ready4, out_valid4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] product4;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready8, out_valid8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_row_multplr #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .product(product4)
  );

  seq_row_multplr #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid on the 4-bit instance; returns cycles waited, in_ready must stay low meanwhile.
  task automatic wait_done4(output int n);
    n = 0;
    while (!out_valid4 && n < 40) begin
      tick();
      n++;
      if (!out_valid4) chk("run_in_ready4", 32'(in_ready4), 0);
    end
  endtask

  task automatic txn4(input logic [3:0] a, input logic [3:0] b, input int stall);
    int n;
    logic [7:0] exp;
    exp = 8'({4'd0, a} * {4'd0, b});
    a4 = a; b4 = b; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    chk("accept_in_ready4", 32'(in_ready4), 0);
    wait_done4(n);
    chk("latency4", 32'(n), 4);
    chk("product4", 32'(product4), 32'(exp));
    if (stall > 0) begin
      out_ready4 = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("stall_valid4", 32'(out_valid4), 1);
        chk("stall_product4", 32'(product4), 32'(exp));
        chk("stall_in_ready4", 32'(in_ready4), 0);
      end
      out_ready4 = 1'b1;
    end
    tick();
    chk("hs_valid4", 32'(out_valid4), 0);
    chk("hs_in_ready4", 32'(in_ready4), 1);
    $display("txn4 a=%0d b=%0d product=%0d stall=%0d", a, b, product4, stall);
  endtask

  task automatic txn8(input logic [7:0] a, input logic [7:0] b);
    int n;
    logic [15:0] exp;
    exp = 16'({8'd0, a} * {8'd0, b});
    a8 = a; b8 = b; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    chk("accept_in_ready8", 32'(in_ready8), 0);
    n = 0;
    while (!out_valid8 && n < 60) begin
      tick();
      n++;
    end
    chk("latency8", 32'(n), 8);
    chk("product8", 32'(product8), 32'(exp));
    tick();
    chk("hs_valid8", 32'(out_valid8), 0);
    $display("txn8 a=%0d b=%0d product=%0d", a, b, product8);
  endtask

  initial begin
    int n;
    int order[$];

    repeat (3) tick();
    chk("rst_in_ready4", 32'(in_ready4), 1);
    chk("rst_out_valid4", 32'(out_valid4), 0);
    chk("rst_product4", 32'(product4), 0);
    chk("rst_in_ready8", 32'(in_ready8), 1);
    rst_n = 1'b1;
    tick();

    // Directed cases, including zero operands and long backpressure.
    txn4(4'd9, 4'd6, 0);
    txn4(4'd15, 4'd15, 0);
    txn4(4'd0, 4'd13, 0);
    txn4(4'd13, 4'd0, 3);
    txn4(4'd11, 4'd7, 10);

    // in_valid held high with changing operands: only 3*5 is used, next pair taken after handshake.
    a4 = 4'd3; b4 = 4'd5; in_valid4 = 1'b1;
    tick();
    n = 0;
    while (!out_valid4 && n < 40) begin
      a4 = 4'($urandom); b4 = 4'($urandom);
      tick();
      n++;
    end
    chk("hold_latency", 32'(n), 4);
    chk("hold_product", 32'(product4), 15);
    a4 = 4'd7; b4 = 4'd2;
    tick();
    chk("hold_hs_valid", 32'(out_valid4), 0);
    chk("hold_hs_in_ready", 32'(in_ready4), 1);
    tick();
    chk("hold_next_accept", 32'(in_ready4), 0);
    in_valid4 = 1'b0;
    wait_done4(n);
    chk("hold_next_latency", 32'(n), 4);
    chk("hold_next_product", 32'(product4), 14);
    tick();
    $display("txn4 hold-valid sequence done");

    // Asynchronous reset between edges mid-RUN.
    a4 = 4'd12; b4 = 4'd10; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready4), 1);
    chk("arst_out_valid", 32'(out_valid4), 0);
    chk("arst_product", 32'(product4), 0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_valid", 32'(out_valid4), 0);
    end
    txn4(4'd7, 4'd11, 0);

    // Exhaustive 4-bit pairs, presented in a shuffled order.
    for (int i = 0; i < 256; i++) order.push_back(i);
    order.shuffle();
    foreach (order[k]) txn4(4'(order[k] >> 4), 4'(order[k]), 0);

    // Random pairs with random stalls.
    for (int i = 0; i < 20; i++)
      txn4(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

    // Wide instance: corners plus random operands.
    txn8(8'd255, 8'd255);
    txn8(8'd0, 8'd200);
    txn8(8'd128, 8'd2);
    for (int i = 0; i < 30; i++) txn8(8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
